// File: rtl/accel_sha_pkg.sv
// rtl/accel_sha_pkg.sv - shared SHA-256 types, widths and bit functions
// Purpose: state encoding for the message scheduler, word/block widths and the
//          SHA-256 sigma/choice/majority helpers used by scheduler and compressor.
// Ports:   none (package).
package accel_sha_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;
    localparam int WIN_LEN = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } ms_state_t;

    // Small sigmas feed the message schedule.
    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Big sigmas, Ch and Maj belong to the round compressor.
    function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e,
                                             input logic [WORD_W-1:0] f,
                                             input logic [WORD_W-1:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a,
                                              input logic [WORD_W-1:0] b,
                                              input logic [WORD_W-1:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/accel_sched_word.sv
// rtl/accel_sched_word.sv - next message-schedule word from the sliding window
// Purpose: w_next = ssig1(w14) + w9 + ssig0(w1) + w0 (mod 2^32).
//          Build option MS_CSA_EN: two chained carry-save adders plus one final add.
// Ports:   w0, w1, w9, w14  in  32  window taps win[0], win[1], win[9], win[14]
//          w_next           out 32  word shifted into win[15]
module accel_sched_word
    import accel_sha_pkg::*;
(
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] w_next
);

    logic [WORD_W-1:0] s1_w14;
    logic [WORD_W-1:0] s0_w1;

    assign s1_w14 = ssig1(w14);
    assign s0_w1  = ssig0(w1);

`ifdef MS_CSA_EN
    logic [WORD_W-1:0] sum_a;
    logic [WORD_W-1:0] carry_a;
    logic [WORD_W-1:0] sum_b;
    logic [WORD_W-1:0] carry_b;

    csa #(.WIDTH(WORD_W)) u_csa0 (
        .a     (s1_w14),
        .b     (w9),
        .c     (s0_w1),
        .sum   (sum_a),
        .carry (carry_a)
    );

    csa #(.WIDTH(WORD_W)) u_csa1 (
        .a     (sum_a),
        .b     (carry_a),
        .c     (w0),
        .sum   (sum_b),
        .carry (carry_b)
    );

    assign w_next = sum_b + carry_b;
`else
    assign w_next = s1_w14 + w9 + s0_w1 + w0;
`endif

endmodule

// File: rtl/csa.sv
// rtl/csa.sv - 3:2 carry-save adder with pre-shifted carry vector
// Purpose: reduces three operands to sum + carry without carry propagation.
// Ports:   a, b, c  in  WIDTH  operands
//          sum      out WIDTH  bitwise sum (a^b^c)
//          carry    out WIDTH  majority carries already shifted left by one;
//                              the top carry falls off, so arithmetic is mod 2^WIDTH
module csa #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[WIDTH-2:0] & b[WIDTH-2:0]) |
                    (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                    (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/accel_msg_scheduler.sv
// rtl/accel_msg_scheduler.sv - SHA-256 message scheduler streaming W[0..63]
// Purpose: latches one 512-bit block and streams one schedule word per clock,
//          aligned so W[t] is presented in compressor round t.
//          Build option MS_CSA_EN selects the carry-save word adder.
// Ports:   clk, rst_n          clock, asynchronous active-low reset
//          ms_load, ms_block   capture block into the window (IDLE only)
//          ms_start            begin streaming (needs a loaded block)
//          w, w_valid, w_idx   schedule word, qualifier, round index
//          ms_busy, ms_done    PRIME/STREAM indicator, end-of-block pulse
module accel_msg_scheduler
    import accel_sha_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ms_load,
    input  logic [BLOCK_W-1:0] ms_block,
    input  logic               ms_start,
    output logic [WORD_W-1:0]  w,
    output logic               w_valid,
    output logic [5:0]         w_idx,
    output logic               ms_busy,
    output logic               ms_done
);

    localparam int CNT_W = $clog2(ROUNDS) + 1;

    ms_state_t         state_q, state_d;
    logic [WORD_W-1:0] win_q [WIN_LEN];
    logic [WORD_W-1:0] win_d [WIN_LEN];
    logic [WORD_W-1:0] w_q, w_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              loaded_q, loaded_d;
    logic [WORD_W-1:0] w_new;
    logic              start_ok;
    logic              last_round;

    // A load in the same cycle counts as loaded for the start decision.
    assign start_ok   = ms_start && (loaded_q || ms_load);
    assign last_round = (cnt_q == CNT_W'(ROUNDS - 1));

    accel_sched_word u_word (
        .w0     (win_q[0]),
        .w1     (win_q[1]),
        .w9     (win_q[9]),
        .w14    (win_q[14]),
        .w_next (w_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = PRIME;
            PRIME:   state_d = STREAM;
            STREAM:  if (last_round) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_valid = (state_q == STREAM);
        ms_busy = (state_q == PRIME) || (state_q == STREAM);
        ms_done = (state_q == FIN);
        w       = w_q;
        w_idx   = cnt_q[5:0];
    end

    // Datapath: w is a separate register so it shows W0 during PRIME and
    // holds W63 after the stream instead of tracking later window contents.
    always_comb begin
        win_d    = win_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        case (state_q)
            IDLE: begin
                if (ms_load) begin
                    for (int i = 0; i < WIN_LEN; i++) begin
                        win_d[i] = ms_block[BLOCK_W-1-WORD_W*i -: WORD_W];
                    end
                    loaded_d = 1'b1;
                end
                if (start_ok) begin
                    w_d = win_d[0];
                end
            end
            STREAM: begin
                for (int i = 0; i < WIN_LEN - 1; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[WIN_LEN-1] = w_new;
                if (!last_round) begin
                    w_d   = win_q[1];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                loaded_d = 1'b0;
                cnt_d    = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                win_q[i] <= '0;
            end
            w_q      <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            win_q    <= win_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

endmodule

// File: tb/tb_accel_msg_scheduler.sv
// tb/tb_accel_msg_scheduler.sv - scoreboard bench for accel_msg_scheduler
module tb_accel_msg_scheduler;

    logic         clk;
    logic         rst_n;
    logic         ms_load;
    logic [511:0] ms_block;
    logic         ms_start;
    logic [31:0]  w;
    logic         w_valid;
    logic [5:0]   w_idx;
    logic         ms_busy;
    logic         ms_done;

    accel_msg_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ms_load  (ms_load),
        .ms_block (ms_block),
        .ms_start (ms_start),
        .w        (w),
        .w_valid  (w_valid),
        .w_idx    (w_idx),
        .ms_busy  (ms_busy),
        .ms_done  (ms_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mw [64];
    logic [31:0] cap [64];
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference schedule in the textbook recurrence form.
    task automatic build_model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) mw[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3);
            s1 = rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10);
            mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int t = 0; t < 64; t++) begin
            e.idx  = 6'(t);
            e.word = mw[t];
            exp_q.push_back(e);
        end
    endtask

    // Round compressor fed by the captured DUT words.
    task automatic compress(output logic [255:0] digest);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3];
        e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + cap[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        digest = {a + H0[0], b + H0[1], c + H0[2], d + H0[3],
                  e + H0[4], f + H0[5], g + H0[6], h + H0[7]};
    endtask

    // Monitor: every valid word is popped against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && w_valid) begin
            cap[w_idx] = w;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got idx %0d word %0h expected no word", w_idx, w);
            end else begin
                e = exp_q.pop_front();
                check("w_idx", 256'(w_idx), 256'(e.idx));
                check("w", 256'(w), 256'(e.word));
            end
        end
    end

    task automatic do_load(input logic [511:0] blk);
        @(negedge clk);
        ms_load = 1'b1; ms_block = blk;
        @(negedge clk);
        ms_load = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        ms_start = 1'b1;
        @(negedge clk);
        ms_start = 1'b0;
    endtask

    task automatic do_load_start(input logic [511:0] blk);
        @(negedge clk);
        ms_load = 1'b1; ms_start = 1'b1; ms_block = blk;
        @(negedge clk);
        ms_load = 1'b0; ms_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (ms_done) seen = 1;
        end
        check(name, 256'(seen), 256'(1));
        @(negedge clk);
        check({name, "_queue_empty"}, 256'(exp_q.size()), 256'(0));
    endtask

    task automatic expect_idle(input string name);
        repeat (3) @(negedge clk);
        check({name, "_busy"}, 256'(ms_busy), 256'(0));
        check({name, "_valid"}, 256'(w_valid), 256'(0));
    endtask

    initial begin
        logic [511:0] blk_abc, blk_b, blk_c, blk_d;
        logic [255:0] digest;
        bit           hit;

        blk_abc = '0;
        blk_abc[511:480] = 32'h61626380;
        blk_abc[31:0]    = 32'h00000018;
        for (int i = 0; i < 16; i++) begin
            blk_b[511-32*i -: 32] = 32'hdeadbeef ^ (32'h01010101 * i);
            blk_c[511-32*i -: 32] = 32'h13579bdf + (32'h00110011 * i);
            blk_d[511-32*i -: 32] = 32'h80000001 ^ (32'h0f0f0f0f << i);
        end

        rst_n = 1'b0; ms_load = 1'b0; ms_start = 1'b0; ms_block = '0;
        repeat (3) @(negedge clk);
        check("rst_w", 256'(w), 256'(0));
        check("rst_valid", 256'(w_valid), 256'(0));
        check("rst_idx", 256'(w_idx), 256'(0));
        check("rst_busy", 256'(ms_busy), 256'(0));
        check("rst_done", 256'(ms_done), 256'(0));
        rst_n = 1'b1;

        // Start with nothing loaded is ignored.
        do_start();
        expect_idle("start_unloaded");

        // "abc" block with cycle-accurate latency checks.
        do_load(blk_abc);
        build_model(blk_abc);
        push_expected();
        do_start();
        check("prime_busy", 256'(ms_busy), 256'(1));
        check("prime_valid", 256'(w_valid), 256'(0));
        check("prime_w", 256'(w), 256'(32'h61626380));
        @(negedge clk);
        check("t2_valid", 256'(w_valid), 256'(1));
        check("t2_idx", 256'(w_idx), 256'(0));
        repeat (63) @(negedge clk);
        check("t65_valid", 256'(w_valid), 256'(1));
        check("t65_idx", 256'(w_idx), 256'(63));
        check("t65_done", 256'(ms_done), 256'(0));
        @(negedge clk);
        check("t66_valid", 256'(w_valid), 256'(0));
        check("t66_done", 256'(ms_done), 256'(1));
        check("t66_busy", 256'(ms_busy), 256'(0));
        check("t66_w_hold", 256'(w), 256'(mw[63]));
        @(negedge clk);
        check("t67_done", 256'(ms_done), 256'(0));
        check("abc_W16", 256'(cap[16]), 256'(32'h61626380));
        check("abc_W17", 256'(cap[17]), 256'(32'h000f0000));
        check("abc_W18", 256'(cap[18]), 256'(32'h7da86405));
        check("abc_W19", 256'(cap[19]), 256'(32'h600003c6));
        compress(digest);
        check("abc_digest", digest,
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        check("abc_queue_empty", 256'(exp_q.size()), 256'(0));

        // loaded was cleared at FIN.
        do_start();
        expect_idle("start_after_fin");

        // Load and start together; a mid-stream load must not disturb the stream.
        build_model(blk_b);
        push_expected();
        do_load_start(blk_b);
        repeat (10) @(negedge clk);
        do_load(blk_c);
        wait_done("blk_b_done");
        do_start();
        expect_idle("start_after_ignored_load");

        // Reset at w_idx = 30 aborts immediately.
        build_model(blk_d);
        push_expected();
        do_load(blk_d);
        do_start();
        hit = 0;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(negedge clk);
            if (w_valid && w_idx == 6'd30) hit = 1;
        end
        check("reached_idx30", 256'(hit), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        check("abort_valid", 256'(w_valid), 256'(0));
        check("abort_busy", 256'(ms_busy), 256'(0));
        check("abort_w", 256'(w), 256'(0));
        check("abort_idx", 256'(w_idx), 256'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        expect_idle("start_after_reset");
        push_expected();
        do_load(blk_d);
        do_start();
        wait_done("blk_d_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
